// File: rtl/scene_painter_pkg.sv
// scene_painter_pkg: frame-buffer geometry, colour codes, FSM state type and clip helper
// Shared with the VGA scan-out so both sides agree on the logical frame size.
package scene_painter_pkg;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  typedef enum logic [2:0] {
    COL_BG     = 3'd0,
    COL_BOTTLE = 3'd1,
    COL_PLAT0  = 3'd2,
    COL_PLAT1  = 3'd3,
    COL_PLAT2  = 3'd4
  } colour_t;
  typedef enum logic [1:0] {IDLE, CLEAR, FILL} state_t;
  // exclusive end coordinate clipped to the frame; 9 bits so start+len never wraps
  function automatic logic [8:0] clip_end(input logic [8:0] start, input logic [8:0] len,
                                          input logic [8:0] lim);
    logic [8:0] s;
    s = start + len;
    return (s > lim) ? lim : s;
  endfunction
endpackage

// File: rtl/scene_painter_if.sv
// scene_painter_if: rectangle command handshake and frame-buffer write port
// cmd_*: command fields with valid/ready; wmem*: one-pixel-per-cycle write strobe bus.
interface scene_painter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [2:0]  cmd_code;
  logic [15:0] wmemaddr;
  logic [2:0]  wmemdata;
  logic        wmemwe;
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_code,
    input  cmd_ready, wmemaddr, wmemdata, wmemwe
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_code,
    output cmd_ready, wmemaddr, wmemdata, wmemwe
  );
endinterface

// File: rtl/scene_painter_rect_scanner.sv
// rect_scanner: row-major x/y/row-base walker over a clipped rectangle
// load latches start/end/base; step advances one pixel; addr = row_base + x; last flags the final pixel.
module rect_scanner #(
  parameter int PX_WIDTH = 160
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [8:0]  x_end,
  input  logic [8:0]  y_end,
  input  logic [15:0] base0,
  output logic [15:0] addr,
  output logic        last
);
  logic [7:0]  x, xs;
  logic [6:0]  y;
  logic [8:0]  xe, ye;
  logic [15:0] row;
  logic        row_end;
  assign row_end = ({1'b0, x} + 9'd1) == xe;
  assign last    = row_end && (({2'b0, y} + 9'd1) == ye);
  assign addr    = row + 16'(x);
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      x   <= '0;
      xs  <= '0;
      y   <= '0;
      xe  <= '0;
      ye  <= '0;
      row <= '0;
    end else if (load) begin
      x   <= x0;
      xs  <= x0;
      y   <= y0;
      xe  <= x_end;
      ye  <= y_end;
      row <= base0;
    end else if (step) begin
      x   <= row_end ? xs : x + 8'd1;
      y   <= row_end ? y + 7'd1 : y;
      row <= row_end ? row + 16'(PX_WIDTH) : row;
    end
endmodule

// File: rtl/scene_painter.sv
// scene_painter: fills rectangles and clears the frame buffer one pixel per dclk
// Ports: dclk/clr (async active-high), clear_req/bg_code clear request, busy status,
// bus: slave side of scene_painter_if (command handshake in, frame-buffer writes out).
module scene_painter
  import scene_painter_pkg::*;
#(
  parameter int PX_WIDTH  = FB_WIDTH,
  parameter int PX_HEIGHT = FB_HEIGHT
) (
  input  logic           dclk,
  input  logic           clr,
  input  logic           clear_req,
  input  logic [2:0]     bg_code,
  output logic           busy,
  scene_painter_if.slave bus
);
  state_t      state, state_n;
  logic        pending;
  logic [2:0]  bg_pend, code, clr_code;
  logic        take_clr, start_clr, start_fill, empty, done, last, load, step;
  logic        cmd_ready, wmemwe;
  logic [7:0]  lx0;
  logic [6:0]  ly0;
  logic [8:0]  lxe, lye;
  logic [15:0] lbase, addr;
  assign empty = bus.cmd_w == 8'd0 || bus.cmd_h == 7'd0 ||
                 {1'b0, bus.cmd_x} >= 9'(PX_WIDTH) || {2'b0, bus.cmd_y} >= 9'(PX_HEIGHT);
  // a request seen this very cycle overrides the latched colour
  assign clr_code = clear_req ? bg_code : bg_pend;
  assign lx0   = start_clr ? 8'd0 : bus.cmd_x;
  assign ly0   = start_clr ? 7'd0 : bus.cmd_y;
  assign lxe   = start_clr ? 9'(PX_WIDTH) : clip_end({1'b0, bus.cmd_x}, {1'b0, bus.cmd_w}, 9'(PX_WIDTH));
  assign lye   = start_clr ? 9'(PX_HEIGHT) : clip_end({2'b0, bus.cmd_y}, {2'b0, bus.cmd_h}, 9'(PX_HEIGHT));
  // constant multiply by the frame width only seeds the row base; the walk itself adds
  assign lbase = start_clr ? 16'd0 : 16'(bus.cmd_y) * 16'(PX_WIDTH);
  rect_scanner #(.PX_WIDTH(PX_WIDTH)) u_scan (
    .dclk  (dclk),
    .clr   (clr),
    .load  (load),
    .step  (step),
    .x0    (lx0),
    .y0    (ly0),
    .x_end (lxe),
    .y_end (lye),
    .base0 (lbase),
    .addr  (addr),
    .last  (last)
  );
  always_ff @(posedge dclk or posedge clr)
    if (clr) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = start_clr ? CLEAR : start_fill ? FILL : done ? IDLE : state;
  end
  // a clear finishing a running operation chains straight into CLEAR with no idle gap
  always_comb begin
    take_clr   = clear_req || pending;
    cmd_ready  = state == IDLE && !take_clr;
    wmemwe     = state != IDLE;
    done       = wmemwe && last;
    start_clr  = take_clr && (state == IDLE || done);
    start_fill = bus.cmd_valid && cmd_ready && !empty;
    load       = start_clr || start_fill;
    step       = wmemwe && !done;
    busy       = state != IDLE || pending;
  end
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      pending <= 1'b0;
      bg_pend <= COL_BG;
      code    <= COL_BG;
    end else begin
      pending <= !start_clr && (pending || clear_req);
      bg_pend <= clear_req ? bg_code : bg_pend;
      code    <= start_clr ? clr_code : start_fill ? bus.cmd_code : code;
    end
  assign bus.cmd_ready = cmd_ready;
  assign bus.wmemwe    = wmemwe;
  assign bus.wmemaddr  = addr;
  assign bus.wmemdata  = code;
endmodule

// File: tb/tb_scene_painter.sv
// tb_scene_painter: scoreboard bench for scene_painter (expected writes queued, monitor compares)
module tb_scene_painter;
  logic       dclk = 1'b0;
  logic       clr = 1'b1;
  logic       clear_req = 1'b0;
  logic [2:0] bg_code = 3'd0;
  logic       busy;
  int         total = 0;
  int         bad = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;

  scene_painter_if bus();
  scene_painter dut (
    .dclk      (dclk),
    .clr       (clr),
    .clear_req (clear_req),
    .bg_code   (bg_code),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [2:0] d);
    exp_q.push_back({a[15:0], d});
  endtask

  task automatic push_clear(input logic [2:0] d, input int last_addr);
    for (int a = 0; a <= last_addr; a++) push(a, d);
  endtask

  always @(negedge dclk)
    if (bus.wmemwe === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_write got=addr %0d data %0d want=no write", bus.wmemaddr, bus.wmemdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {13'd0, bus.wmemaddr, bus.wmemdata}, {13'd0, mon_e});
      end
    end

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge dclk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h, input logic [2:0] c);
    @(negedge dclk);
    bus.cmd_x = x[7:0];
    bus.cmd_y = y[6:0];
    bus.cmd_w = w[7:0];
    bus.cmd_h = h[6:0];
    bus.cmd_code = c;
    bus.cmd_valid = 1'b1;
    #1 chk("cmd_ready_before_take", bus.cmd_ready, 1);
    @(posedge dclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = 8'($urandom);
    bus.cmd_y = 7'($urandom);
    bus.cmd_w = 8'($urandom);
    bus.cmd_h = 7'($urandom);
    bus.cmd_code = 3'($urandom);
  endtask

  task automatic pulse_clear(input logic [2:0] c);
    @(negedge dclk);
    clear_req = 1'b1;
    bg_code = c;
    @(posedge dclk);
    #1 clear_req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_code = '0;
    repeat (3) @(negedge dclk);
    chk("rst_we", bus.wmemwe, 0);
    chk("rst_addr", bus.wmemaddr, 0);
    chk("rst_data", bus.wmemdata, 0);
    chk("rst_busy", busy, 0);
    clr = 1'b0;
    @(negedge dclk);
    chk("rst_ready", bus.cmd_ready, 1);

    // full clear with colour 5
    push_clear(3'd5, 19199);
    @(negedge dclk);
    clear_req = 1'b1;
    bg_code = 3'd5;
    #1 chk("clear_blocks_ready", bus.cmd_ready, 0);
    @(posedge dclk);
    #1 clear_req = 1'b0;
    bg_code = 3'd0;
    @(negedge dclk);
    chk("clear_busy", busy, 1);
    wait_drain(19300, "clear_drain");
    @(negedge dclk);
    chk("clear_done_busy", busy, 0);
    chk("clear_done_we", bus.wmemwe, 0);
    chk("clear_hold_addr", bus.wmemaddr, 19199);
    chk("clear_hold_data", bus.wmemdata, 5);

    // 3x2 rectangle, exact cycle count and ready return
    push(330, 3'd1); push(331, 3'd1); push(332, 3'd1);
    push(490, 3'd1); push(491, 3'd1); push(492, 3'd1);
    send_cmd(10, 2, 3, 2, 3'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge dclk);
      chk("fill_we_run", bus.wmemwe, 1);
      chk("fill_not_ready", bus.cmd_ready, 0);
    end
    @(negedge dclk);
    chk("fill_end_we", bus.wmemwe, 0);
    chk("fill_end_ready", bus.cmd_ready, 1);
    chk("fill_hold_addr", bus.wmemaddr, 492);
    chk("fill_q_empty", exp_q.size(), 0);

    // clipped at bottom-right corner
    push(19198, 3'd4); push(19199, 3'd4);
    send_cmd(158, 119, 10, 5, 3'd4);
    wait_drain(10, "clip_drain");
    @(negedge dclk);
    chk("clip_idle", busy, 0);

    // degenerate commands: consumed without writes
    send_cmd(5, 5, 0, 3, 3'd2);
    @(negedge dclk);
    chk("w0_we", bus.wmemwe, 0);
    chk("w0_ready", bus.cmd_ready, 1);
    send_cmd(160, 0, 4, 4, 3'd2);
    @(negedge dclk);
    chk("xoob_ready", bus.cmd_ready, 1);
    send_cmd(0, 120, 4, 4, 3'd2);
    @(negedge dclk);
    chk("yoob_ready", bus.cmd_ready, 1);
    send_cmd(7, 7, 3, 0, 3'd2);
    @(negedge dclk);
    chk("h0_ready", bus.cmd_ready, 1);
    chk("h0_busy", busy, 0);

    // two clear pulses during a 10x10 fill collapse to one trailing clear
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) push((30 + r) * 160 + 20 + c, 3'd3);
    push_clear(3'd6, 19199);
    send_cmd(20, 30, 10, 10, 3'd3);
    repeat (10) @(negedge dclk);
    pulse_clear(3'd6);
    @(negedge dclk);
    chk("pend_busy", busy, 1);
    chk("pend_not_ready", bus.cmd_ready, 0);
    repeat (30) @(negedge dclk);
    pulse_clear(3'd6);
    wait_drain(20000, "fill_then_clear_drain");
    repeat (30) @(negedge dclk);
    chk("after_one_clear_busy", busy, 0);
    chk("after_one_clear_ready", bus.cmd_ready, 1);

    // clear beats a simultaneous command, then clr aborts at address 500
    push_clear(3'd2, 500);
    @(negedge dclk);
    clear_req = 1'b1;
    bg_code = 3'd2;
    bus.cmd_x = 8'd0;
    bus.cmd_y = 7'd0;
    bus.cmd_w = 8'd4;
    bus.cmd_h = 7'd4;
    bus.cmd_code = 3'd7;
    bus.cmd_valid = 1'b1;
    #1 chk("clear_wins_ready", bus.cmd_ready, 0);
    @(posedge dclk);
    #1 clear_req = 1'b0;
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge dclk);
      if (bus.wmemwe === 1'b1 && bus.wmemaddr == 16'd500) found = 1'b1;
    end
    chk("abort_reached_500", found, 1);
    #1 clr = 1'b1;
    #1;
    chk("abort_we", bus.wmemwe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", bus.wmemaddr, 0);
    chk("abort_data", bus.wmemdata, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge dclk);
    clr = 1'b0;
    @(negedge dclk);
    chk("post_abort_ready", bus.cmd_ready, 1);
    repeat (20) @(negedge dclk);
    chk("post_abort_busy", busy, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scene_painter.md
SCENE_PAINTER -- requirements
Module: scene_painter

Interface
REQ-001 Parameter PX_WIDTH, default 160, logical frame-buffer width in 4x4 screen pixels.
REQ-002 Parameter PX_HEIGHT, default 120, logical frame-buffer height.
REQ-003 dclk  in  1  clock; the same 25 MHz pixel clock as the VGA scan-out.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 clear_req  in  1  one-cycle pulse requesting a full-buffer fill with bg_code.
REQ-006 bg_code  in  3  colour code used by the clear; sampled on the cycle clear_req is taken.
REQ-007 cmd_valid  in  1  rectangle command valid.
REQ-008 cmd_ready  out  1  block accepts a command this cycle.
REQ-009 cmd_x  in  8  left column; cmd_y  in  7  top row.
REQ-010 cmd_w  in  8  width; cmd_h  in  7  height; cmd_code  in  3  colour code.
REQ-011 wmemaddr  out  16  frame-buffer write address, y*PX_WIDTH+x.
REQ-012 wmemdata  out  3  colour code written.
REQ-013 wmemwe  out  1  write strobe, one pixel per asserted cycle.
REQ-014 busy  out  1  high whenever the state is not IDLE or a clear is pending.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR and FILL.
REQ-016 A command SHALL be taken when cmd_valid and cmd_ready are both high on a dclk edge; cmd_ready SHALL be high only in IDLE with no pending clear.
REQ-017 All cmd_* fields SHALL be registered on acceptance; input changes afterwards SHALL have no effect.
REQ-018 The first write of an accepted command or clear SHALL appear on the cycle after acceptance; writes SHALL follow one per cycle with no gaps.
REQ-019 The scan order SHALL be row-major: x increments first, then y; row base advances by adding PX_WIDTH, with no multiplier.
REQ-020 Clipping: x_end = min(cmd_x+cmd_w, PX_WIDTH) and y_end = min(cmd_y+cmd_h, PX_HEIGHT), computed 9 bits wide so there is no wrap-around.
REQ-021 A command with cmd_w=0, cmd_h=0, cmd_x>=PX_WIDTH or cmd_y>=PX_HEIGHT SHALL be consumed with zero writes and return to IDLE within 1 cycle.
REQ-022 CLEAR SHALL write addresses 0..PX_WIDTH*PX_HEIGHT-1 in order with bg_code, then return to IDLE.
REQ-023 A clear_req arriving during FILL or CLEAR SHALL be latched as pending and serviced immediately after the current operation ends; multiple pending requests SHALL collapse to one.
REQ-024 If clear_req and cmd_valid are both high in IDLE, clear SHALL win and the command SHALL not be accepted.
REQ-025 wmemwe SHALL be low in IDLE; wmemaddr and wmemdata SHALL hold their last values when wmemwe is low.
REQ-026 A w x h rectangle that is fully in bounds SHALL take exactly w*h write cycles, and cmd_ready SHALL return high on the cycle after the last write.

Reset
REQ-027 On clr, the state SHALL go to IDLE, the pending clear SHALL be cleared, and wmemwe, wmemaddr, wmemdata and busy SHALL all be 0; cmd_ready SHALL be 1 once clr deasserts.
REQ-028 A clr asserted mid-FILL or mid-CLEAR SHALL abort with no further writes; partially drawn pixels SHALL remain in memory.

Structure
REQ-029 PX_WIDTH, PX_HEIGHT and the colour-code constants (0 background, 1 bottle, 2-4 platforms) SHALL live in the shared consts include file used by the VGA scan-out.
REQ-030 One sub-module, rect_scanner, SHALL hold the x/y/row-base counters and the end-of-rectangle flag; it SHALL be used by both CLEAR (full-frame bounds) and FILL.

Verification
REQ-031 Bench: clear_req with bg_code=5 -> 19200 consecutive writes, addr 0..19199, data 5, then busy=0.
REQ-032 Bench: cmd x=10, y=2, w=3, h=2, code=1 -> 6 writes at addresses 330, 331, 332, 490, 491, 492, each with data 1.
REQ-033 Bench: cmd x=158, y=119, w=10, h=5 -> only addresses 19198 and 19199 are written.
REQ-034 Bench: cmd w=0 -> no wmemwe pulse, and cmd_ready returns within 2 cycles.
REQ-035 Bench: clear_req pulsed twice during a 100-pixel FILL -> FILL completes, then exactly one CLEAR runs.
REQ-036 Bench: clr asserted mid-CLEAR at address 500 -> wmemwe drops the same cycle, state is IDLE, and no further writes occur.
